// File: rtl/instr_assembler.sv
// RV32I instruction encoder and loader: packs structured requests into 32-bit words
// and writes them to instruction memory at an auto-incrementing, wrapping address.
module instr_assembler #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_type,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic [15:0]           count,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;

  logic [31:0] word;
  logic        legal;

  assign in_ready = (state == IDLE) && !start;
  assign legal    = (in_type <= 4'd8);

  always_comb begin
    word = 32'h0;
    case (in_type)
      4'd0: word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      4'd1: word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      4'd2: word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      4'd3: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      4'd4: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      4'd5: word = {imm[31:12], rd, 7'b0010111};
      4'd6: word = {imm[31:12], rd, 7'b0110111};
      4'd7: word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      4'd8: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      default: word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 32'h0;
      count     <= 16'h0;
      err       <= 1'b0;
    end else if (start) begin
      // Restart drops any pending write; mem_wdata keeps its last value.
      state    <= IDLE;
      mem_we   <= 1'b0;
      mem_addr <= BASE;
      count    <= 16'h0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (legal) begin
              mem_wdata <= word;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_addr <= mem_addr + ADDR_WIDTH'(4);
            if (count != 16'hFFFF) count <= count + 16'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: encodings, handshake, backpressure, start/reset and wrap.
module tb_instr_assembler;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, mem_ready;
  logic [3:0]  in_type;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        in_ready, mem_we, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] count;
  logic        w_in_ready, w_mem_we, w_err;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [15:0] w_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_assembler dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .err(err)
  );

  instr_assembler #(.ADDR_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_type(in_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .mem_ready(mem_ready), .count(w_count), .err(w_err)
  );

  // Present one request for a single clock edge.
  task automatic issue(input logic [3:0] t, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    in_type = t; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_type = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7 = 0; imm = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    checks++; if (count !== 16'h0 || err !== 1'b0) begin errors++; $display("FAIL reset_count_err got=%0d/%b exp=0/0", count, err); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: in_ready=%b mem_we=%b addr=%h count=%0d", in_ready, mem_we, mem_addr, count);
  endtask

  task automatic test_addi();
    mem_ready = 1'b1;
    issue(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL addi_we got=%b exp=1", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL addi_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h00500093) begin errors++; $display("FAIL addi_word got=%h exp=00500093", mem_wdata); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL addi_busy got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (count !== 16'd1 || mem_addr !== 32'h4) begin errors++; $display("FAIL addi_commit got=%0d/%h exp=1/4", count, mem_addr); end
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL addi_idle got=%b/%b exp=0/1", mem_we, in_ready); end
    $display("addi: word=%h count=%0d addr=%h", mem_wdata, count, mem_addr);
  endtask

  task automatic test_sequence();
    start = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL start_blocks_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1; start = 1'b0;
    checks++; if (mem_addr !== 32'h0 || count !== 16'd0) begin errors++; $display("FAIL seq_restart got=%h/%0d exp=0/0", mem_addr, count); end
    mem_ready = 1'b1;
    issue(4'd6, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    checks++; if (mem_wdata !== 32'h12345137) begin errors++; $display("FAIL lui_word got=%h exp=12345137", mem_wdata); end
    @(posedge clk); #1;
    issue(4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    checks++; if (mem_wdata !== 32'h008000EF || mem_addr !== 32'h4) begin errors++; $display("FAIL jal_word got=%h@%h exp=008000ef@4", mem_wdata, mem_addr); end
    @(posedge clk); #1;
    checks++; if (mem_addr !== 32'h8 || count !== 16'd2) begin errors++; $display("FAIL seq_final got=%h/%0d exp=8/2", mem_addr, count); end
    $display("sequence: addr=%h count=%0d", mem_addr, count);
  endtask

  task automatic test_encodings();
    mem_ready = 1'b1;
    issue(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    checks++; if (mem_wdata !== 32'hFE208EE3) begin errors++; $display("FAIL b_word got=%h exp=fe208ee3", mem_wdata); end
    @(posedge clk); #1;
    issue(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    checks++; if (mem_wdata !== 32'h0020A423) begin errors++; $display("FAIL s_word got=%h exp=0020a423", mem_wdata); end
    @(posedge clk); #1;
    issue(4'd7, 5'd1, 5'd2, 5'd0, 3'd5, 7'd0, 32'hFFFF_FFF8);
    checks++; if (mem_wdata !== 32'hFF8100E7) begin errors++; $display("FAIL jalr_word got=%h exp=ff8100e7", mem_wdata); end
    @(posedge clk); #1;
    issue(4'd1, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, 32'd12);
    checks++; if (mem_wdata !== 32'h00C32283) begin errors++; $display("FAIL load_word got=%h exp=00c32283", mem_wdata); end
    @(posedge clk); #1;
    issue(4'd5, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    checks++; if (mem_wdata !== 32'h00001197) begin errors++; $display("FAIL auipc_word got=%h exp=00001197", mem_wdata); end
    @(posedge clk); #1;
    checks++; if (count !== 16'd7 || mem_addr !== 32'h1C) begin errors++; $display("FAIL enc_commit got=%0d/%h exp=7/1c", count, mem_addr); end
    $display("encodings: count=%0d addr=%h", count, mem_addr);
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    issue(4'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    checks++; if (mem_wdata !== 32'h403100B3) begin errors++; $display("FAIL r_word got=%h exp=403100b3", mem_wdata); end
    in_valid = 1'b1; in_type = 4'd6; imm = 32'hABCDE000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h1C || mem_wdata !== 32'h403100B3 || in_ready !== 1'b0 || count !== 16'd7) begin
        errors++;
        $display("FAIL stall_%0d got=we%b addr%h data%h rdy%b cnt%0d exp=we1 addr1c data403100b3 rdy0 cnt7",
                 i, mem_we, mem_addr, mem_wdata, in_ready, count);
      end
    end
    in_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (count !== 16'd8 || mem_addr !== 32'h20 || mem_we !== 1'b0) begin errors++; $display("FAIL stall_release got=%0d/%h/%b exp=8/20/0", count, mem_addr, mem_we); end
    $display("backpressure: count=%0d addr=%h", count, mem_addr);
  endtask

  task automatic test_illegal();
    issue(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b exp=1", err); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h20 || count !== 16'd8) begin errors++; $display("FAIL illegal_nowrite got=%b/%h/%0d exp=0/20/8", mem_we, mem_addr, count); end
    pulse_start();
    checks++; if (err !== 1'b0 || count !== 16'd0 || mem_addr !== 32'h0) begin errors++; $display("FAIL illegal_start got=%b/%0d/%h exp=0/0/0", err, count, mem_addr); end
    $display("illegal: err cleared=%b count=%0d addr=%h", err, count, mem_addr);
  endtask

  task automatic test_start_abort();
    mem_ready = 1'b0;
    issue(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL abort_pre_we got=%b exp=1", mem_we); end
    start = 1'b1; in_valid = 1'b1; in_type = 4'd7; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    checks++; if (mem_we !== 1'b0 || count !== 16'd0 || mem_addr !== 32'h0) begin errors++; $display("FAIL abort_state got=%b/%0d/%h exp=0/0/0", mem_we, count, mem_addr); end
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b0 || count !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_not_taken got=%b/%0d/%b exp=0/0/1", mem_we, count, in_ready); end
    $display("start_abort: mem_we=%b count=%0d", mem_we, count);
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b0;
    issue(4'd6, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_5000);
    @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b1 || mem_wdata !== 32'h0) begin errors++; $display("FAIL async_reset got=%b/%b/%h exp=0/1/0", mem_we, in_ready, mem_wdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (count !== 16'd0 || mem_addr !== 32'h0) begin errors++; $display("FAIL async_reset_nocommit got=%0d/%h exp=0/0", count, mem_addr); end
    $display("async_reset: mem_we=%b count=%0d", mem_we, count);
  endtask

  task automatic test_wrap();
    logic [3:0] exp_w [4];
    exp_w[0] = 4'h4; exp_w[1] = 4'h8; exp_w[2] = 4'hC; exp_w[3] = 4'h0;
    pulse_start();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(4'd2, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      @(posedge clk); #1;
      checks++;
      if (w_mem_addr !== exp_w[i] || mem_addr !== 32'(4 * (i + 1))) begin
        errors++;
        $display("FAIL wrap_%0d got=%h/%h exp=%h/%h", i, w_mem_addr, mem_addr, exp_w[i], 32'(4 * (i + 1)));
      end
    end
    checks++; if (w_count !== 16'd4 || w_err !== 1'b0) begin errors++; $display("FAIL wrap_count got=%0d/%b exp=4/0", w_count, w_err); end
    $display("wrap: narrow addr=%h wide addr=%h", w_mem_addr, mem_addr);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sequence();
    test_encodings();
    test_backpressure();
    test_illegal();
    test_start_abort();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_assembler.md
# instr_assembler

Sequential RV32I instruction encoder: the inverse of the main control decoder. Accepts one instruction request per handshake (class, register indices, funct fields, immediate), packs it into a 32-bit RV32I word, and writes it into instruction memory at an auto-incrementing address. Sits beside the fetch stage as the self-test / boot-program loader. Programs the pipeline from structured stimulus without a prebuilt hex file.

## Interface

Parameters:
- ADDR_WIDTH, 32, memory address width
- BASE_ADDR, 32'h0000_0000, first write address after reset or `start`

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  restart program: pointer to BASE_ADDR, clear count and err
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_type  in  4  class: 0 R, 1 I-load, 2 I-ALU, 3 S, 4 B, 5 AUIPC, 6 LUI, 7 JALR, 8 JAL; 9-15 illegal
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R only)
- imm  in  32  immediate, byte-offset form, sign-extended
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  word-aligned write address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- count  out  16  instructions written since reset/start, saturating
- err  out  1  sticky: an illegal in_type was received

## Operation

- FSM: IDLE, WRITE.
- IDLE: in_ready = !start. Handshake = in_valid & in_ready.
  - Legal class: register encoded word into mem_wdata, go to WRITE.
  - Illegal class: set err, no write, stay IDLE.
- WRITE: in_ready=0, mem_we=1, mem_addr/mem_wdata held stable.
  - On mem_ready: mem_addr += 4, count += 1 (saturates at 16'hFFFF), go to IDLE.
- Encoding, opcode field bits[6:0]:
  - R: funct7|rs2|rs1|funct3|rd|0110011
  - I-load / I-ALU / JALR: imm[11:0]|rs1|funct3|rd|0000011 / 0010011 / 1100111. JALR forces funct3 = 000.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011. imm[0] ignored.
  - AUIPC / LUI: imm[31:12]|rd|0010111 / 0110111
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111. imm[0] ignored.
- Unused input fields for a class are ignored; no range checking on imm.
- mem_addr wraps modulo 2^ADDR_WIDTH. No fault on wrap.
- start, any state, highest priority:
  - Next cycle: IDLE, mem_addr=BASE_ADDR, count=0, err=0.
  - A pending write is dropped and mem_we deasserts.
  - A same-cycle request is not accepted, since in_ready is low.

## Timing

- Reset values (asynchronous):
  - State IDLE, in_ready=1, mem_we=0.
  - mem_addr=BASE_ADDR, mem_wdata=0, count=0, err=0.
- Latency: request accepted at edge N → mem_we=1 with valid word/address from cycle N+1.
- Write completes at the first edge with mem_ready=1. Earliest re-accept is the cycle after.
- Throughput: 1 instruction per 2 cycles when mem_ready is tied high.
- mem_ready is ignored outside WRITE.
- err is set at the edge of an illegal handshake and visible the next cycle.
- Reset mid-WRITE: mem_we drops immediately (asynchronous), nothing is committed.

## Test plan

- Reset, then in_type=2, rd=1, rs1=0, funct3=0, imm=5 → next cycle mem_we=1, mem_addr=0, mem_wdata=32'h00500093. With mem_ready=1: count=1, mem_addr=4.
- Sequence, mem_ready held high:
  - LUI rd=2, imm=32'h12345000 → 32'h12345137
  - JAL rd=1, imm=8 → 32'h008000EF
  - Expect final mem_addr=8, count=2.
- B: rs1=1, rs2=2, funct3=0, imm=-4 → 32'hFE208EE3. S: rs1=1, rs2=2, funct3=2, imm=8 → 32'h0020A423.
- Backpressure: mem_ready low 5 cycles in WRITE → mem_we, mem_addr, mem_wdata stable; in_ready=0; count unchanged until mem_ready rises.
- in_type=12 → err=1, no mem_we, mem_addr unchanged. Then start → err=0, count=0, mem_addr=BASE_ADDR.
- start asserted mid-WRITE with in_valid high → write aborted, no count increment, request not accepted that cycle. ADDR_WIDTH=4 with 4 writes → mem_addr wraps 12→0.
